// File: rtl/display_number_n.sv
// display_number_n: shows an unsigned binary value as NUM_DIGITS decimal
// glyphs at a fixed screen position. A serial double-dabble converter loads
// the value, and the result is committed to the display on a frame boundary.
// The module also handles leading-zero blanking, overflow saturation, blink
// and programmable colours. The file also holds the combinational digit
// glyph ROM.

module digit (
  input  logic [3:0]  number,
  input  logic [3:0]  row,
  output logic [11:0] pixels
);
  logic [6:0] seg;  // {g,f,e,d,c,b,a}

  // Seven-segment map per decimal digit; codes above 9 draw nothing
  always_comb begin
    case (number)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

  // One 12-pixel glyph row; bit 11 is the leftmost column
  always_comb begin
    pixels = 12'h000;
    if (seg[0] && row >= 4'd1 && row <= 4'd2)  pixels = pixels | 12'h3FC;
    if (seg[1] && row >= 4'd1 && row <= 4'd7)  pixels = pixels | 12'h006;
    if (seg[2] && row >= 4'd8 && row <= 4'd14) pixels = pixels | 12'h006;
    if (seg[3] && row >= 4'd13 && row <= 4'd14) pixels = pixels | 12'h3FC;
    if (seg[4] && row >= 4'd8 && row <= 4'd14) pixels = pixels | 12'h600;
    if (seg[5] && row >= 4'd1 && row <= 4'd7)  pixels = pixels | 12'h600;
    if (seg[6] && row >= 4'd7 && row <= 4'd8)  pixels = pixels | 12'h3FC;
  end
endmodule

module display_number_n #(
  parameter int NUM_DIGITS   = 4,
  parameter int VALUE_W      = 14,
  parameter int X0           = 300,
  parameter int Y0           = 200,
  parameter int PITCH_LOG2   = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         vga_col,
  input  logic [8:0]         vga_row,
  input  logic               frame_start,
  input  logic [VALUE_W-1:0] value_in,
  input  logic               value_valid,
  output logic               value_ready,
  input  logic               lz_blank,
  input  logic               blink_en,
  input  logic [11:0]        fg_color,
  input  logic [11:0]        bg_color,
  output logic               overflow,
  output logic               pixel_on,
  output logic [11:0]        pixel_data
);
  localparam int BCD_W = 4 * (NUM_DIGITS + 1);
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + (NUM_DIGITS << PITCH_LOG2));
  localparam logic [9:0]  Y_LO = 10'(Y0);
  localparam logic [9:0]  Y_HI = 10'(Y0 + 16);

  typedef enum logic [1:0] {IDLE, CONV, PEND} state_t;

  state_t                       state_reg;
  logic                         value_ready_reg;
  logic [VALUE_W-1:0]           bin_reg;
  logic [BCD_W-1:0]             bcd_reg;
  logic                         carry_reg;
  logic [CNT_W-1:0]             cnt_reg;
  logic [NUM_DIGITS-1:0][3:0]   shown_reg;     // index 0 = most significant
  logic                         shown_ovf_reg;
  logic [BLK_W-1:0]             blink_cnt_reg;
  logic                         blink_hidden_reg;
  logic                         pixel_on_reg;
  logic [11:0]                  pixel_data_reg;

  logic [BCD_W-1:0]             bcd_adj;
  logic [BCD_W-1:0]             bcd_next;
  logic                         carry_out;
  logic                         pend_ovf;
  logic [NUM_DIGITS-1:0][3:0]   pend_digits;

  // Double-dabble correction: add 3 to every nibble that is 5 or more
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS + 1; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
    // Pending digits in display order, saturated to 9s on overflow
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_pend
      assign pend_digits[gi] = pend_ovf ? 4'd9 : bcd_reg[4*(NUM_DIGITS-1-gi) +: 4];
    end
  endgenerate

  assign bcd_next  = {bcd_adj[BCD_W-2:0], bin_reg[VALUE_W-1]};
  assign carry_out = bcd_adj[BCD_W-1];
  assign pend_ovf  = carry_reg | (bcd_reg[BCD_W-1 -: 4] != 4'd0);

  // Load / convert / wait-for-frame sequencer with frame-synchronous commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      value_ready_reg <= 1'b1;
      bin_reg         <= '0;
      bcd_reg         <= '0;
      carry_reg       <= 1'b0;
      cnt_reg         <= '0;
      shown_reg       <= '0;
      shown_ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (value_valid) begin
            bin_reg         <= value_in;
            bcd_reg         <= '0;
            carry_reg       <= 1'b0;
            cnt_reg         <= '0;
            state_reg       <= CONV;
            value_ready_reg <= 1'b0;
          end
        end
        CONV: begin
          bcd_reg   <= bcd_next;
          bin_reg   <= bin_reg << 1;
          carry_reg <= carry_reg | carry_out;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(VALUE_W - 1)) state_reg <= PEND;
        end
        PEND: begin
          if (frame_start) begin
            shown_reg       <= pend_digits;
            shown_ovf_reg   <= pend_ovf;
            state_reg       <= IDLE;
            value_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg       <= IDLE;
          value_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // Blink phase: toggles every BLINK_FRAMES frame pulses while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_reg    <= '0;
      blink_hidden_reg <= 1'b0;
    end else if (!blink_en) begin
      blink_cnt_reg    <= '0;
      blink_hidden_reg <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt_reg == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg    <= '0;
        blink_hidden_reg <= ~blink_hidden_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  logic [10:0]           col_ext;
  logic [10:0]           rel_col;
  logic [10:0]           idx_full;
  logic [9:0]            row_ext;
  logic                  in_box;
  logic [PITCH_LOG2-1:0] glyph_col;
  logic [3:0]            glyph_col4;
  logic [3:0]            rom_row;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_run;
  logic                  glyph_bit;
  logic                  glyph_on;
  logic [11:0]           rom_bits;

  // Pixel geometry, digit selection and leading-zero blanking
  always_comb begin
    col_ext    = {1'b0, vga_col};
    row_ext    = {1'b0, vga_row};
    in_box     = (col_ext >= X_LO) && (col_ext < X_HI) &&
                 (row_ext >= Y_LO) && (row_ext < Y_HI);
    rel_col    = col_ext - X_LO;
    idx_full   = rel_col >> PITCH_LOG2;
    glyph_col  = rel_col[PITCH_LOG2-1:0];
    glyph_col4 = 4'(glyph_col);
    rom_row    = 4'(row_ext - Y_LO);
    zero_run   = 1'b1;
    blank      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_run = zero_run & (shown_reg[i] == 4'd0);
      if (i != NUM_DIGITS - 1) blank[i] = lz_blank & ~shown_ovf_reg & zero_run;
    end
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_full == 11'(i)) begin
        cur_digit = shown_reg[i];
        cur_blank = blank[i];
      end
    end
    glyph_bit = 1'b0;
    if (32'(glyph_col) < 32'd12) glyph_bit = rom_bits[4'd11 - glyph_col4];
    glyph_on = in_box && !cur_blank && !(blink_en && blink_hidden_reg) && glyph_bit;
  end

  digit u_digit (
    .number (cur_digit),
    .row    (rom_row),
    .pixels (rom_bits)
  );

  // Registered pixel output, one cycle behind vga_col/vga_row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_on_reg   <= 1'b0;
      pixel_data_reg <= 12'h000;
    end else begin
      pixel_on_reg   <= in_box;
      pixel_data_reg <= in_box ? (glyph_on ? fg_color : bg_color) : 12'h000;
    end
  end

  assign value_ready = value_ready_reg;
  assign overflow    = shown_ovf_reg;
  assign pixel_on    = pixel_on_reg;
  assign pixel_data  = pixel_data_reg;
endmodule

// File: tb/tb_display_number_n.sv
// Randomized self-checking bench for display_number_n with a behavioural
// model: integer display value, decimal digit extraction and a seven-segment
// font described as rectangles.

module tb_display_number_n;
  localparam int ND = 4;
  localparam int VW = 14;
  localparam int X0 = 300;
  localparam int Y0 = 200;
  localparam int PL = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    vga_col;
  logic [8:0]    vga_row;
  logic          frame_start;
  logic [VW-1:0] value_in;
  logic          value_valid;
  logic          value_ready;
  logic          lz_blank;
  logic          blink_en;
  logic [11:0]   fg_color;
  logic [11:0]   bg_color;
  logic          overflow;
  logic          pixel_on;
  logic [11:0]   pixel_data;

  int tests_run = 0;
  int tests_failed = 0;
  int m_val = 0;
  bit m_ovf = 1'b0;
  int blink_pulses = 0;
  int seg_mask [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  display_number_n #(
    .NUM_DIGITS(ND), .VALUE_W(VW), .X0(X0), .Y0(Y0),
    .PITCH_LOG2(PL), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .vga_col(vga_col), .vga_row(vga_row),
    .frame_start(frame_start), .value_in(value_in), .value_valid(value_valid),
    .value_ready(value_ready), .lz_blank(lz_blank), .blink_en(blink_en),
    .fg_color(fg_color), .bg_color(bg_color), .overflow(overflow),
    .pixel_on(pixel_on), .pixel_data(pixel_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Seven-segment font as rectangles inside a 12x16 cell
  function automatic bit glyph(input int d, input int c, input int r);
    int s;
    bit on;
    s  = seg_mask[d];
    on = 0;
    if (c >= 12) return 0;
    if (s[0] && r >= 1 && r <= 2  && c >= 2 && c <= 9)  on = 1;
    if (s[1] && r >= 1 && r <= 7  && c >= 9 && c <= 10) on = 1;
    if (s[2] && r >= 8 && r <= 14 && c >= 9 && c <= 10) on = 1;
    if (s[3] && r >= 13 && r <= 14 && c >= 2 && c <= 9) on = 1;
    if (s[4] && r >= 8 && r <= 14 && c >= 1 && c <= 2)  on = 1;
    if (s[5] && r >= 1 && r <= 7  && c >= 1 && c <= 2)  on = 1;
    if (s[6] && r >= 7 && r <= 8  && c >= 2 && c <= 9)  on = 1;
    return on;
  endfunction

  function automatic logic [11:0] model_pixel(input int c, input int r);
    int i, gc, gr, disp, p10, d;
    bit blanked, hidden, lit;
    if (c < X0 || c >= X0 + ND * 16 || r < Y0 || r >= Y0 + 16) return 12'h000;
    i  = (c - X0) / 16;
    gc = (c - X0) % 16;
    gr = r - Y0;
    disp = m_ovf ? 9999 : m_val;
    p10 = 1;
    for (int k = 0; k < ND - 1 - i; k++) p10 = p10 * 10;
    d = (disp / p10) % 10;
    blanked = lz_blank && !m_ovf && (i != ND - 1) && ((disp / p10) == 0);
    hidden  = blink_en && (((blink_pulses / BF) % 2) == 1);
    lit = !blanked && !hidden && glyph(d, gc, gr);
    return lit ? fg_color : bg_color;
  endfunction

  task automatic check_pixel(input int c, input int r);
    bit in_box;
    in_box  = (c >= X0 && c < X0 + ND * 16 && r >= Y0 && r < Y0 + 16);
    vga_col = 10'(c);
    vga_row = 9'(r);
    step();
    check_val($sformatf("pix_data(%0d,%0d)", c, r), 32'(pixel_data), 32'(model_pixel(c, r)));
    check_val($sformatf("pix_on(%0d,%0d)", c, r), 32'(pixel_on), 32'(in_box));
  endtask

  task automatic rand_pixels(input int n);
    for (int k = 0; k < n; k++)
      check_pixel(int'($urandom_range(X0 - 4, X0 + ND * 16 + 3)),
                  int'($urandom_range(Y0 - 2, Y0 + 17)));
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    if (blink_en) blink_pulses++;
  endtask

  // Load v; fs_at (1..13) pulses frame_start mid-conversion, defer pulses
  // it on the final conversion cycle. Neither may commit.
  task automatic do_load(input int v, input bit defer, input int fs_at);
    int waited;
    waited = 0;
    while (!value_ready && waited < 100) begin
      step();
      waited++;
    end
    check_val("ready_before_load", 32'(value_ready), 32'd1);
    value_in = VW'(v);
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      check_val("ready_low_conv", 32'(value_ready), 32'd0);
      if (k == fs_at) frame_start = 1'b1;
      if (k == 3) begin
        value_valid = 1'b1;
        value_in = VW'(v ^ 32'h1555);
      end
      step();
      frame_start = 1'b0;
      value_valid = 1'b0;
    end
    if (defer) frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_val("ready_low_pend", 32'(value_ready), 32'd0);
    check_val("ovf_before_commit", 32'(overflow), 32'(m_ovf));
    rand_pixels(4);
    check_val("ready_still_low", 32'(value_ready), 32'd0);
    pulse_frame();
    m_val = v;
    m_ovf = (v > 9999);
    check_val("ready_after_commit", 32'(value_ready), 32'd1);
    check_val("ovf_after_commit", 32'(overflow), 32'(m_ovf));
    $display("[TB] load %0d lz=%0d defer=%0d fs_at=%0d -> shows %0d ovf=%0d",
             v, lz_blank, defer, fs_at, m_ovf ? 9999 : m_val, m_ovf);
  endtask

  initial begin
    rst = 1'b1;
    vga_col = '0;
    vga_row = '0;
    frame_start = 1'b0;
    value_in = '0;
    value_valid = 1'b0;
    lz_blank = 1'b0;
    blink_en = 1'b0;
    fg_color = 12'hFA5;
    bg_color = 12'h123;
    step();
    step();
    check_val("rst_ready", 32'(value_ready), 32'd1);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    check_val("rst_pixel_on", 32'(pixel_on), 32'd0);
    check_val("rst_pixel_data", 32'(pixel_data), 32'd0);
    rst = 1'b0;
    step();

    // Reset display: "0000", then only the LS '0' with blanking
    check_pixel(X0 + 5, Y0 + 1);
    rand_pixels(12);
    lz_blank = 1'b1;
    check_pixel(X0 + 5, Y0 + 1);
    check_pixel(X0 + 48 + 5, Y0 + 1);
    rand_pixels(12);
    lz_blank = 1'b0;

    do_load(1234, 1'b0, 5);
    check_pixel(X0 + 16 + 11, Y0 + 3);
    check_pixel(X0 + 16 + 12, Y0 + 3);
    check_pixel(X0 - 1, Y0 + 3);
    check_pixel(X0 + 16 + 10, Y0 + 3);
    rand_pixels(16);

    do_load(12000, 1'b0, 0);
    rand_pixels(12);
    lz_blank = 1'b1;
    do_load(7, 1'b0, 0);
    check_pixel(X0 + 5, Y0 + 1);
    check_pixel(X0 + 48 + 5, Y0 + 1);
    rand_pixels(12);

    do_load(8888, 1'b1, 0);
    rand_pixels(8);

    for (int n = 0; n < 12; n++) begin
      lz_blank = 1'($urandom_range(0, 1));
      fg_color = 12'($urandom);
      bg_color = 12'($urandom);
      do_load(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 13)));
      rand_pixels(10);
    end

    // Blink: visible BF frames, hidden BF frames, repeating
    lz_blank = 1'b0;
    do_load(8888, 1'b0, 0);
    blink_en = 1'b1;
    blink_pulses = 0;
    step();
    for (int f = 0; f < 9; f++) begin
      check_pixel(X0 + 48 + 5, Y0 + 7);
      rand_pixels(2);
      pulse_frame();
    end
    blink_en = 1'b0;
    blink_pulses = 0;
    step();
    check_pixel(X0 + 48 + 5, Y0 + 7);

    // Asynchronous reset in the middle of a conversion
    lz_blank = 1'b1;
    value_in = VW'(5678);
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check_val("arst_ready", 32'(value_ready), 32'd1);
    check_val("arst_pixel_on", 32'(pixel_on), 32'd0);
    step();
    rst = 1'b0;
    m_val = 0;
    m_ovf = 1'b0;
    pulse_frame();
    check_val("arst_ovf", 32'(overflow), 32'd0);
    check_pixel(X0 + 5, Y0 + 1);
    check_pixel(X0 + 48 + 5, Y0 + 1);
    rand_pixels(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
